// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the width rule for the window/gap down-counter.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } ps_state_t;

  // Wide enough to hold max(high, gap) - 1; never narrower than one bit.
  function automatic int ps_cnt_width(input int high_cycles, input int gap_cycles);
    int m;
    m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ps_down_counter.sv
// Loadable down-counter that parks at zero; the owner reloads it on each phase.
module ps_down_counter
  import pulse_stretcher_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous, so it lives inside the clocked block rather than the list.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into fixed high windows followed by a
// guaranteed low gap, queueing strobes that arrive mid-window.
// Optional: define PULSE_STRETCHER_RETRIGGER_EN to let strobes during HIGH
// extend the current window instead of queueing.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter  int HIGH_CYCLES = 4,
  parameter  int GAP_CYCLES  = 2,
  parameter  int PEND_DEPTH  = 3,
  localparam int PW          = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  output logic          level_out,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int          CW          = ps_cnt_width(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HIGH_RELOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_RELOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_FULL   = PW'(PEND_DEPTH);

  ps_state_t     state;
  logic          cnt_load;
  logic          cnt_en;
  logic [CW-1:0] cnt_val;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          retrigger;
  logic          queue_req;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  assign retrigger = (state == HIGH) && pulse_in;
`else
  assign retrigger = 1'b0;
`endif

  // A strobe is queued unless it starts a window directly or retriggers one.
  assign queue_req = pulse_in &&
                     (((state == HIGH) && !retrigger) ||
                      ((state == GAP)  && !cnt_zero));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    unique case (state)
      IDLE: begin
        if (pulse_in) begin
          cnt_load = 1'b1;
          cnt_val  = HIGH_RELOAD;
        end
      end
      HIGH: begin
        if (retrigger) begin
          cnt_load = 1'b1;
          cnt_val  = HIGH_RELOAD;
        end else if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = GAP_RELOAD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      GAP: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (pulse_in || (pending != '0)) begin
          cnt_load = 1'b1;
          cnt_val  = HIGH_RELOAD;
        end
      end
      default: ;
    endcase
  end

  ps_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      level_out <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (queue_req) begin
        if (pending == PEND_FULL) overflow <= 1'b1;
        else                      pending  <= pending + PW'(1);
      end
      unique case (state)
        IDLE: begin
          if (pulse_in) begin
            state     <= HIGH;
            level_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HIGH: begin
          if (!retrigger && cnt_zero) begin
            state     <= GAP;
            level_out <= 1'b0;
          end
        end
        GAP: begin
          // Last gap cycle: a live strobe wins over the queue, leaving pending as is.
          if (cnt_zero) begin
            if (pulse_in || (pending != '0)) begin
              state     <= HIGH;
              level_out <= 1'b1;
              if (!pulse_in) pending <= pending - PW'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          level_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: directed strobe patterns push per-cycle
// expected outputs; a negedge monitor pops and compares them.
module tb_pulse_stretcher;

  localparam int NCYC = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic       level_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  always #5 clk = ~clk;

  pulse_stretcher dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .level_out (level_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic       level;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int cyc,
                       input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.name, ".level_out"}, e.cyc, {1'b0, level_out}, {1'b0, e.level});
      check({e.name, ".busy"},      e.cyc, {1'b0, busy},      {1'b0, e.busy});
      check({e.name, ".pending"},   e.cyc, pending,           e.pend);
      check({e.name, ".overflow"},  e.cyc, {1'b0, overflow},  {1'b0, e.ovf});
    end
  end

  // Cycle 0 is the first cycle after the reset edge, so it doubles as a reset check.
  task automatic run_test(input string name,
                          input logic [63:0] pmask, input logic [63:0] rmask,
                          input logic [63:0] lmask, input logic [63:0] bmask,
                          input logic [63:0] p0mask, input logic [63:0] p1mask,
                          input logic [63:0] omask);
    exp_t e;
    rst      = 1'b1;
    pulse_in = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      rst      = rmask[k];
      pulse_in = pmask[k];
      e.name   = name;
      e.cyc    = k;
      e.level  = lmask[k];
      e.busy   = bmask[k];
      e.pend   = {p1mask[k], p0mask[k]};
      e.ovf    = omask[k];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    pulse_in = 1'b0;
  endtask

  initial begin
    // single strobe
    run_test("single", rng(10, 10), '0,
             rng(11, 14), rng(11, 16), '0, '0, '0);
    // second strobe queued during the first window
    run_test("queued", rng(10, 10) | rng(12, 12), '0,
             rng(11, 14) | rng(17, 20), rng(11, 22), rng(13, 16), '0, '0);
    // held input fills the queue and drops one request
    run_test("overflow", rng(10, 14), '0,
             rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32), rng(11, 34),
             rng(12, 12) | rng(14, 16) | rng(23, 28), rng(13, 22), rng(15, 15));
    // strobe on the last gap cycle chains straight into a new window
    run_test("last_gap", rng(10, 10) | rng(16, 16), '0,
             rng(11, 14) | rng(17, 20), rng(11, 22), '0, '0, '0);
    // reset mid-window with a strobe in the reset cycle
    run_test("reset_mid", rng(10, 13), rng(13, 13),
             rng(11, 13), rng(11, 13), rng(12, 12), rng(13, 13), '0);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    run_test("retrigger", rng(10, 10) | rng(13, 13), '0,
             rng(11, 17), rng(11, 19), '0, '0, '0);
`else
    run_test("high_queue", rng(10, 10) | rng(13, 13), '0,
             rng(11, 14) | rng(17, 20), rng(11, 22), rng(14, 16), '0, '0);
`endif
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

- Converts single-cycle strobes into clean, fixed-width high windows separated by a guaranteed low gap. It is the inverse of the level-to-pulse edge detection used on the input side.
- Sits between game logic and consumers that need a sustained level: sound/LED blinkers, slow-domain handshakes, debug probes.
- Strobes arriving while a window is in progress are queued, not lost.
- Mandatory minimum gap: consecutive windows are always distinguishable.

## Interface
Parameters:
- HIGH_CYCLES, 4, length of each high window in clk cycles (≥1)
- GAP_CYCLES, 2, minimum low time after each window (≥1)
- PEND_DEPTH, 3, max queued strobes (≥1); PW = $clog2(PEND_DEPTH+1)

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- pulse_in  input  1  strobe; each high cycle is one request
- level_out  output  1  registered stretched level
- busy  output  1  registered, 1 whenever state ≠ IDLE
- pending  output  PW  registered count of queued requests
- overflow  output  1  registered one-cycle flag: request dropped because queue full

## Operation
States:
- **IDLE**: level_out=0.
  - pulse_in=1 → HIGH, counter loaded HIGH_CYCLES-1.
- **HIGH**: level_out=1; counter decrements each cycle.
  - Counter==0 → GAP, counter loaded GAP_CYCLES-1.
- **GAP**: level_out=0; counter decrements each cycle.
  - At counter==0: pulse_in=1 or pending>0 → HIGH (reload); else → IDLE.

Queue rules:
- pulse_in during HIGH/GAP not consumed this cycle → pending+1.
- pending==PEND_DEPTH → request dropped, overflow=1 next cycle only.

Simultaneous events at the last GAP cycle:
- pulse_in=1, pending=0 → strobe consumed directly; pending stays 0.
- pulse_in=1, pending>0 → one request in, one out; pending unchanged, no overflow.
- pulse_in=0, pending>0 → pending-1.

Counter arithmetic: width $clog2(max(HIGH_CYCLES,GAP_CYCLES)), unsigned, never wraps (reloaded at 0).

Reset (any cycle, including mid-window): next cycle state=IDLE, level_out=0, busy=0, pending=0, overflow=0, counter=0. pulse_in in a reset cycle is ignored.

## Timing
- Latency: pulse_in high in cycle N → level_out high in cycles N+1 … N+HIGH_CYCLES.
- busy high from N+1 through the end of GAP.
- Back-to-back windows: period exactly HIGH_CYCLES+GAP_CYCLES, no IDLE cycle between them.
- pending and overflow update one cycle after the triggering pulse_in.
- All outputs are registered; no combinational path from pulse_in.

## Configuration
Macro: PULSE_STRETCHER_RETRIGGER_EN.
- Defined: pulse_in during HIGH reloads the counter to HIGH_CYCLES-1, extending the current window. The strobe is not queued and pending is unchanged. pulse_in during GAP queues as normal.
- Undefined: pulse_in during HIGH queues per Operation.

## Structure
- Package pulse_stretcher_pkg holds:
  - typedef enum logic [1:0] {IDLE, HIGH, GAP} ps_state_t
  - function for counter-width computation
- One sub-module, `ps_down_counter`: loadable down-counter with load value, enable and zero flag. Instantiated once; reloaded by the FSM.

## Test plan
Defaults unless noted; HIGH=4, GAP=2, DEPTH=3.
1. Single pulse, cycle 10 → level_out=1 cycles 11–14; busy=1 cycles 11–16; IDLE in 17; pending stays 0.
2. Pulses at 10 and 12 → high 11–14 and 17–20; pending=1 cycles 13–16, 0 from 17.
3. pulse_in held high cycles 10–14 → pending 1,2,3 in cycles 12,13,14; overflow=1 cycle 15 only; four windows: 11–14, 17–20, 23–26, 29–32.
4. Pulse at 10, pulse at 16 (last GAP cycle) → high 17–20 with no IDLE cycle; pending stays 0.
5. Pulses 10,11,12, rst=1 at cycle 13 with pulse_in=1 → cycle 14: level_out=0, pending=0, busy=0; nothing further emitted.
6. With PULSE_STRETCHER_RETRIGGER_EN, pulses at 10 and 13 → level_out=1 cycles 11–17, GAP 18–19; pending stays 0.
